mov_fsm: RTL and testbench
==========================

MOV_FSM -- requirements
Module: mov_fsm

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst  input  1  asynchronous active-low reset; 0 forces reset state immediately.
REQ-004 fullBitNum  input  16  instruction word: [15:12] opcode, [11:6] reserved, [5:3] destination code, [2:0] source code.
REQ-005 PC_inc  output  1  program-counter increment strobe.
REQ-006 done  output  1  instruction-complete strobe.
REQ-007 G0_in, G1_in, G2_in, G3_in, P0_in, P1_in  output  1 each  load enable of the destination register.
REQ-008 G0_out, G1_out, G2_out, G3_out, P0_out, P1_out  output  1 each  bus-drive enable of the source register.

Function
REQ-009 Register codes SHALL be: 0=G0, 1=G1, 2=G2, 3=G3, 4=P0, 5=P1; codes 6 and 7 are invalid.
REQ-010 MOV opcode SHALL be 4'b0110; reserved bits [11:6] SHALL be ignored.
REQ-011 States SHALL be IDLE, DECODE, TRANSFER, DONE.
REQ-012 IDLE: if fullBitNum[15:12]==0110 at a clock edge, latch fullBitNum and go to DECODE; otherwise stay in IDLE.
REQ-013 DECODE SHALL always go to TRANSFER on the next edge.
REQ-014 TRANSFER SHALL always go to DONE on the next edge.
REQ-015 DONE SHALL always go to IDLE on the next edge.
REQ-016 Outputs SHALL be Moore: functions only of the state and the latched instruction; fullBitNum changes after latching SHALL have no effect.
REQ-017 In TRANSFER, exactly the source _out and the destination _in enables SHALL be 1; all other enables SHALL be 0.
REQ-018 If source equals destination, that register's _in and _out SHALL both be 1 in TRANSFER.
REQ-019 If either code is invalid, no enable SHALL assert in TRANSFER; the FSM still proceeds to DONE.
REQ-020 In DONE, done=1 and PC_inc=1 for exactly one cycle; both SHALL be 0 in every other state.
REQ-021 All enables SHALL be 0 in IDLE, DECODE and DONE.
REQ-022 One MOV SHALL take 4 cycles from the start edge back to IDLE.
REQ-023 A MOV word held constant on the input SHALL re-execute every 4 cycles.

Reset
REQ-024 rst=0 SHALL force IDLE, clear the latched instruction, and drive every output to 0 asynchronously, including mid-operation.
REQ-025 After rst returns to 1, the first start SHALL occur at the first rising edge with a MOV opcode present.

Configuration
REQ-026 Macro MOV_FSM_PREGS_EN defined: P0/P1 (codes 4, 5) are valid per REQ-009.
REQ-027 Macro MOV_FSM_PREGS_EN undefined: codes 4 and 5 are treated as invalid, and P0_in, P0_out, P1_in, P1_out SHALL be tied to 0.

Structure
REQ-028 A shared package mov_fsm_pkg SHALL hold the state enum, the MOV opcode constant, and the 3-bit register-code constants.
REQ-029 One sub-module, mov_reg_decoder, SHALL map a 3-bit code plus an enable to a one-hot 6-bit vector; it SHALL be instantiated twice (source, destination).

Verification
REQ-030 Reset: rst=0 mid-TRANSFER -> all outputs 0 immediately, then state IDLE.
REQ-031 MOV G0<-G2: fullBitNum=16'h6002 after reset release -> edge1 DECODE, edge2 G2_out=G0_in=1 for one cycle, edge3 done=PC_inc=1 for one cycle, edge4 IDLE.
REQ-032 Non-MOV: fullBitNum=16'h5002 for 10 cycles -> FSM stays in IDLE, all outputs 0.
REQ-033 Invalid code: fullBitNum=16'h6007 -> no enables in TRANSFER, done=PC_inc=1 in DONE.
REQ-034 P-register and latching: fullBitNum=16'h6021 (P0<-G1), changed to 16'h0000 after the start edge -> G1_out=P0_in=1 in TRANSFER; with MOV_FSM_PREGS_EN undefined, no enables assert.
REQ-035 Self-move and repeat: fullBitNum=16'h601B (G3<-G3) held constant -> G3_in=G3_out=1 together, execution repeats every 4 cycles.

Source files
------------

// File: rtl/mov_fsm_pkg.sv
// Shared types and constants for the MOV controller: state encoding, opcode and register codes.
// Configuration macro MOV_FSM_PREGS_EN (see mov_fsm.sv) decides whether P0/P1 codes are accepted.
package mov_fsm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DECODE   = 2'd1,
      ST_TRANSFER = 2'd2,
      ST_DONE     = 2'd3
   } state_t;

   localparam logic [3:0] MOV_OPCODE = 4'b0110;

   localparam int unsigned NUM_REGS = 6;

   localparam logic [2:0] REG_G0 = 3'd0;
   localparam logic [2:0] REG_G1 = 3'd1;
   localparam logic [2:0] REG_G2 = 3'd2;
   localparam logic [2:0] REG_G3 = 3'd3;
   localparam logic [2:0] REG_P0 = 3'd4;
   localparam logic [2:0] REG_P1 = 3'd5;

endpackage

// File: rtl/mov_reg_decoder.sv
// Maps a 3-bit register code to a one-hot select vector, gated by an enable.
// Bit order of sel: [0]=G0 [1]=G1 [2]=G2 [3]=G3 [4]=P0 [5]=P1; codes 6 and 7 select nothing.
module mov_reg_decoder
   import mov_fsm_pkg::*;
(
   input  logic [2:0]          code,
   input  logic                en,
   output logic [NUM_REGS-1:0] sel
);

   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
      sel = '0;
      if (en) begin
         case (code)
            REG_G0:  sel[0] = 1'b1;
            REG_G1:  sel[1] = 1'b1;
            REG_G2:  sel[2] = 1'b1;
            REG_G3:  sel[3] = 1'b1;
            REG_P0:  sel[4] = 1'b1;
            REG_P1:  sel[5] = 1'b1;
            default: sel    = '0;
         endcase
      end
   end

endmodule

// File: rtl/mov_fsm.sv
// Four-state MOV controller: latches a MOV word, drives one source/destination enable pair, then strobes done/PC_inc.
// Define MOV_FSM_PREGS_EN to make P0/P1 (codes 4, 5) legal operands; otherwise they are invalid and their enables tie to 0.
module mov_fsm
   import mov_fsm_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] fullBitNum,
   output logic        PC_inc,
   output logic        done,
   output logic        G0_in,
   output logic        G1_in,
   output logic        G2_in,
   output logic        G3_in,
   output logic        P0_in,
   output logic        P1_in,
   output logic        G0_out,
   output logic        G1_out,
   output logic        G2_out,
   output logic        G3_out,
   output logic        P0_out,
   output logic        P1_out
);

   state_t               state_q, state_d;
   logic [2:0]           src_q, dst_q;
   logic                 start;
   logic                 src_ok, dst_ok, xfer_en;
   logic [NUM_REGS-1:0]  src_sel, dst_sel;
   logic                 unused_bits;

   // Only the opcode and the two register codes matter; the reserved field is deliberately dropped.
   assign start       = (fullBitNum[15:12] == MOV_OPCODE);
   assign unused_bits = ^fullBitNum[11:6];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         state_q <= state_d;
         if (state_q == ST_IDLE && start) begin
            src_q <= fullBitNum[2:0];
            dst_q <= fullBitNum[5:3];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:     state_d = start ? ST_DECODE : ST_IDLE;
         ST_DECODE:   state_d = ST_TRANSFER;
         ST_TRANSFER: state_d = ST_DONE;
         ST_DONE:     state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

`ifdef MOV_FSM_PREGS_EN
   assign src_ok = (src_q <= REG_P1);
   assign dst_ok = (dst_q <= REG_P1);
`else
   assign src_ok = (src_q <= REG_G3);
   assign dst_ok = (dst_q <= REG_G3);
`endif

   // A single bad operand suppresses the whole transfer rather than half of it.
   assign xfer_en = (state_q == ST_TRANSFER) && src_ok && dst_ok;

   mov_reg_decoder u_src_dec (
      .code (src_q),
      .en   (xfer_en),
      .sel  (src_sel)
   );

   mov_reg_decoder u_dst_dec (
      .code (dst_q),
      .en   (xfer_en),
      .sel  (dst_sel)
   );

   assign done   = (state_q == ST_DONE);
   assign PC_inc = (state_q == ST_DONE);

   assign G0_in  = dst_sel[0];
   assign G1_in  = dst_sel[1];
   assign G2_in  = dst_sel[2];
   assign G3_in  = dst_sel[3];
   assign G0_out = src_sel[0];
   assign G1_out = src_sel[1];
   assign G2_out = src_sel[2];
   assign G3_out = src_sel[3];

`ifdef MOV_FSM_PREGS_EN
   assign P0_in  = dst_sel[4];
   assign P1_in  = dst_sel[5];
   assign P0_out = src_sel[4];
   assign P1_out = src_sel[5];
`else
   logic unused_psel;
   assign unused_psel = ^{dst_sel[5:4], src_sel[5:4]};
   assign P0_in  = 1'b0;
   assign P1_in  = 1'b0;
   assign P0_out = 1'b0;
   assign P1_out = 1'b0;
`endif

endmodule

// File: tb/tb_mov_fsm.sv
// Directed self-checking bench for mov_fsm; all 14 outputs are compared as one vector per sampled cycle.
// Vector layout: {PC_inc, done, G0_in..G3_in, P0_in, P1_in, G0_out..G3_out, P0_out, P1_out}.
module tb_mov_fsm;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] fullBitNum;
   logic        PC_inc, done;
   logic        G0_in, G1_in, G2_in, G3_in, P0_in, P1_in;
   logic        G0_out, G1_out, G2_out, G3_out, P0_out, P1_out;
   logic [13:0] outs;

   int checks = 0;
   int errors = 0;

   localparam logic [13:0] ZERO       = 14'b00_000000_000000;
   localparam logic [13:0] DONE_V     = 14'b11_000000_000000;
   localparam logic [13:0] G0_FROM_G2 = 14'b00_100000_001000;
   localparam logic [13:0] G3_FROM_G3 = 14'b00_000100_000100;
`ifdef MOV_FSM_PREGS_EN
   localparam logic [13:0] P0_FROM_G1 = 14'b00_000010_010000;
`else
   localparam logic [13:0] P0_FROM_G1 = ZERO;
`endif

   always #5 clk = ~clk;

   mov_fsm dut (
      .clk        (clk),
      .rst        (rst),
      .fullBitNum (fullBitNum),
      .PC_inc     (PC_inc),
      .done       (done),
      .G0_in      (G0_in),
      .G1_in      (G1_in),
      .G2_in      (G2_in),
      .G3_in      (G3_in),
      .P0_in      (P0_in),
      .P1_in      (P1_in),
      .G0_out     (G0_out),
      .G1_out     (G1_out),
      .G2_out     (G2_out),
      .G3_out     (G3_out),
      .P0_out     (P0_out),
      .P1_out     (P1_out)
   );

   assign outs = {PC_inc, done, G0_in, G1_in, G2_in, G3_in, P0_in, P1_in,
                  G0_out, G1_out, G2_out, G3_out, P0_out, P1_out};

   task automatic check(input string tag, input logic [13:0] got, input logic [13:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%b expected=%b", tag, got, exp);
      end
   endtask

   // One rising edge, then sample on the following falling edge.
   task automatic cyc();
      @(negedge clk);
   endtask

   initial begin
      rst        = 1'b0;
      fullBitNum = 16'h0000;
      #3;
      check("reset_outputs", outs, ZERO);
      cyc(); cyc();
      check("reset_held", outs, ZERO);
      rst = 1'b1;

      // G0 <- G2; input cleared after the start edge so the FSM must settle back in IDLE.
      fullBitNum = 16'h6002;
      cyc(); check("g0g2_decode", outs, ZERO);
      fullBitNum = 16'h0000;
      cyc(); check("g0g2_transfer", outs, G0_FROM_G2);
      cyc(); check("g0g2_done", outs, DONE_V);
      cyc(); check("g0g2_idle", outs, ZERO);
      cyc(); check("g0g2_stay_idle", outs, ZERO);

      // Non-MOV opcode must never start.
      fullBitNum = 16'h5002;
      for (int i = 0; i < 10; i++) begin
         cyc(); check($sformatf("nonmov_%0d", i), outs, ZERO);
      end

      // Invalid source code: no enables, but done still fires.
      fullBitNum = 16'h6007;
      cyc(); check("inv_decode", outs, ZERO);
      fullBitNum = 16'h0000;
      cyc(); check("inv_transfer", outs, ZERO);
      cyc(); check("inv_done", outs, DONE_V);
      cyc(); check("inv_idle", outs, ZERO);

      // P0 <- G1 with reserved bits set; input changed after latching.
      fullBitNum = 16'h6FE1;
      cyc(); check("p0g1_decode", outs, ZERO);
      fullBitNum = 16'h0000;
      cyc(); check("p0g1_transfer", outs, P0_FROM_G1);
      cyc(); check("p0g1_done", outs, DONE_V);
      cyc(); check("p0g1_idle", outs, ZERO);

      // G3 <- G3 held constant: repeats with a 4-cycle period.
      fullBitNum = 16'h601B;
      for (int rep = 0; rep < 2; rep++) begin
         cyc(); check($sformatf("self_decode_%0d", rep), outs, ZERO);
         cyc(); check($sformatf("self_transfer_%0d", rep), outs, G3_FROM_G3);
         cyc(); check($sformatf("self_done_%0d", rep), outs, DONE_V);
         cyc(); check($sformatf("self_idle_%0d", rep), outs, ZERO);
      end
      fullBitNum = 16'h0000;
      cyc(); check("self_stop", outs, ZERO);

      // Reset asserted mid-TRANSFER clears outputs without waiting for a clock edge.
      fullBitNum = 16'h6002;
      cyc(); check("rst_mid_decode", outs, ZERO);
      cyc(); check("rst_mid_transfer", outs, G0_FROM_G2);
      #2 rst = 1'b0;
      #1 check("rst_mid_async", outs, ZERO);
      cyc(); check("rst_mid_held", outs, ZERO);
      rst = 1'b1;
      cyc(); check("rst_restart_decode", outs, ZERO);
      fullBitNum = 16'h0000;
      cyc(); check("rst_restart_transfer", outs, G0_FROM_G2);
      cyc(); check("rst_restart_done", outs, DONE_V);
      cyc(); check("rst_restart_idle", outs, ZERO);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
